line_buf_ctrl: RTL and testbench

- Sequencing controller for the 3-line buffer that feeds the Sobel 3x3 window.
- Watches the incoming video timing (de, vsync) and generates line-RAM write enables, addresses and bank rotation, plus window-valid and border flags for the kernel.
- Emits one trailing flush line per frame so the last image row is still produced.
- Sits between the video timing source and the line-buffer RAMs / Sobel datapath.

---
 rtl/lbc_pkg.sv | 26 ++
 rtl/lbc_edge_det.sv | 23 ++
 rtl/line_buf_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_line_buf_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbc_pkg.sv
// Shared types and helpers for the line-buffer controller: FSM state encoding and
// the three-bank rotation used by the Sobel line RAMs.
package lbc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } lbc_state_e;

    localparam logic [1:0] BANK_0 = 2'd0;
    localparam logic [1:0] BANK_1 = 2'd1;
    localparam logic [1:0] BANK_2 = 2'd2;

    // (b + 1) mod 3
    function automatic logic [1:0] next_bank(input logic [1:0] b);
        return (b == BANK_2) ? BANK_0 : (b + BANK_1);
    endfunction

    // (b + 2) mod 3, i.e. the bank written one line earlier
    function automatic logic [1:0] prev_bank(input logic [1:0] b);
        return (b == BANK_0) ? BANK_2 : (b - BANK_1);
    endfunction

endpackage

// File: rtl/lbc_edge_det.sv
// Registered edge detector: one flop of history, combinational rise/fall pulses
// valid in the cycle the input changes.
module lbc_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q, sig_d;

    always_comb sig_d = sig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_d;
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/line_buf_ctrl.sv
// Sequencer for the 3-line Sobel buffer: line-RAM writes, bank rotation, window valid,
// border flags and one trailing flush line. Build macro LBC_LEN_CHECK_EN adds err_len.
//
//  state | meaning
//  IDLE  | waiting for frame start (vsync fall)
//  FILL  | writing line 0, no window output yet
//  RUN   | writing line N, windows centred on line N-1
//  FLUSH | replaying the last line as bottom row, no writes
module line_buf_ctrl
    import lbc_pkg::*;
#(
    parameter  int WIDTH = 640,
    parameter  int DEPTH = 480,
    localparam int AW    = $clog2(WIDTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          de,
    input  logic          vsync,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [1:0]    wr_bank,
    output logic [1:0]    mid_bank,
    output logic [1:0]    top_bank,
    output logic          bot_repl,
    output logic          win_valid,
    output logic          first_row,
    output logic          last_row,
    output logic          first_col,
    output logic          last_col,
    output logic [LW-1:0] line_cnt,
    output logic          err_ovf
`ifdef LBC_LEN_CHECK_EN
    ,
    output logic          err_len
`endif
);

    localparam int LENW = $clog2(WIDTH + 1);

    lbc_state_e      state_q, state_d;
    logic [AW-1:0]   col_cnt_q, col_cnt_d;
    logic            full_q, full_d;
    logic [LW-1:0]   line_cnt_q, line_cnt_d;
    logic [1:0]      wr_bank_q, wr_bank_d;
    logic [LENW-1:0] line_len_q, line_len_d;
    logic            err_ovf_q, err_ovf_d;
    logic            win_valid_q, win_valid_d;
    logic            first_row_q, first_row_d;
    logic            last_row_q, last_row_d;
    logic            first_col_q, first_col_d;
    logic            last_col_q, last_col_d;

    logic            de_rise, de_fall, vs_rise, vs_fall;
    logic            active, ovf_now, rd_stb, flush_stb, line_end;
    logic            col_at_last, flush_done;
    logic [LENW-1:0] pix_cnt;

    lbc_edge_det u_de_edge (.clk(clk), .rst(rst), .sig(de),    .rise(de_rise), .fall(de_fall));
    lbc_edge_det u_vs_edge (.clk(clk), .rst(rst), .sig(vsync), .rise(vs_rise), .fall(vs_fall));

    // col_cnt saturates at WIDTH-1; full_q marks that the last column was written too
    assign pix_cnt     = LENW'(col_cnt_q) + LENW'(full_q);
    assign col_at_last = (LENW'(col_cnt_q) == (line_len_q - LENW'(1)));
    assign flush_done  = (line_len_q == '0) || col_at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vs_fall) state_d = FILL;
            FILL:    if (vs_rise) state_d = FLUSH;
                     else if (de_fall) state_d = RUN;
            RUN:     if (vs_fall) state_d = FILL;
                     else if (vs_rise) state_d = FLUSH;
            FLUSH:   if (vs_fall) state_d = FILL;
                     else if (flush_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        active    = (state_q == FILL) || (state_q == RUN);
        wr_en     = de & active & ~full_q;
        ovf_now   = de & active & full_q;
        flush_stb = (state_q == FLUSH) && (line_len_q != '0);
        rd_stb    = (de && (state_q == RUN)) || flush_stb;
        bot_repl  = (state_q == FLUSH);
    end

    always_comb begin
        col_cnt_d  = col_cnt_q;
        full_d     = full_q;
        line_cnt_d = line_cnt_q;
        wr_bank_d  = wr_bank_q;
        line_len_d = line_len_q;
        err_ovf_d  = err_ovf_q | ovf_now;
        line_end   = active & de_fall;
        if ((state_q != FILL) && (state_d == FILL)) begin
            col_cnt_d  = '0;
            full_d     = 1'b0;
            line_cnt_d = '0;
            wr_bank_d  = BANK_0;
            line_len_d = '0;
        end else begin
            if (de_rise) full_d = 1'b0;
            if (wr_en) begin
                if (col_cnt_q == AW'(WIDTH - 1)) full_d = 1'b1;
                else                             col_cnt_d = col_cnt_q + AW'(1);
            end
            if (line_end) begin
                col_cnt_d = '0;
                full_d    = 1'b0;
                wr_bank_d = next_bank(wr_bank_q);
                if (state_q == FILL) begin
                    line_len_d = pix_cnt;
                    line_cnt_d = LW'(1);
                end else if (line_cnt_q != LW'(DEPTH)) begin
                    line_cnt_d = line_cnt_q + LW'(1);
                end
            end
            if (flush_stb) col_cnt_d = col_cnt_q + AW'(1);
            // line-end bookkeeping above still applies when vsync rises on the same cycle
            if ((state_q != FLUSH) && (state_d == FLUSH)) begin
                col_cnt_d = '0;
                full_d    = 1'b0;
            end
        end
    end

    always_comb begin
        win_valid_d = rd_stb;
        first_col_d = rd_stb && (col_cnt_q == '0);
        last_col_d  = rd_stb && col_at_last;
        first_row_d = rd_stb && (line_cnt_q == LW'(1));
        last_row_d  = rd_stb && (state_q == FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q   <= '0;
            full_q      <= 1'b0;
            line_cnt_q  <= '0;
            wr_bank_q   <= BANK_0;
            line_len_q  <= '0;
            err_ovf_q   <= 1'b0;
            win_valid_q <= 1'b0;
            first_row_q <= 1'b0;
            last_row_q  <= 1'b0;
            first_col_q <= 1'b0;
            last_col_q  <= 1'b0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            full_q      <= full_d;
            line_cnt_q  <= line_cnt_d;
            wr_bank_q   <= wr_bank_d;
            line_len_q  <= line_len_d;
            err_ovf_q   <= err_ovf_d;
            win_valid_q <= win_valid_d;
            first_row_q <= first_row_d;
            last_row_q  <= last_row_d;
            first_col_q <= first_col_d;
            last_col_q  <= last_col_d;
        end
    end

`ifdef LBC_LEN_CHECK_EN
    logic err_len_q, err_len_d;

    always_comb err_len_d = err_len_q | (de_fall && (state_q == RUN) && (pix_cnt != line_len_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_len_q <= 1'b0;
        else     err_len_q <= err_len_d;
    end

    assign err_len = err_len_q;
`endif

    assign wr_addr   = col_cnt_q;
    assign wr_bank   = wr_bank_q;
    assign mid_bank  = prev_bank(wr_bank_q);
    assign top_bank  = next_bank(wr_bank_q);
    assign win_valid = win_valid_q;
    assign first_row = first_row_q;
    assign last_row  = last_row_q;
    assign first_col = first_col_q;
    assign last_col  = last_col_q;
    assign line_cnt  = line_cnt_q;
    // the overflowing cycle itself already reports the error
    assign err_ovf   = err_ovf_q | ovf_now;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl (WIDTH=12, DEPTH=5): frames of random line lengths checked
// against a frame-level model of expected writes and windows.
module tb_line_buf_ctrl;

    localparam int W = 12;
    localparam int D = 5;

    logic clk = 1'b0;
    logic rst, de, vsync;
    logic wr_en;
    logic [$clog2(W)-1:0] wr_addr;
    logic [1:0] wr_bank, mid_bank, top_bank;
    logic bot_repl, win_valid, first_row, last_row, first_col, last_col;
    logic [$clog2(D+1)-1:0] line_cnt;
    logic err_ovf;
`ifdef LBC_LEN_CHECK_EN
    logic err_len;
    bit   exp_len_err;
`endif

    typedef struct { int cyc; int bank; int addr; int mid; int top; } wr_rec_t;
    typedef struct { int cyc; logic fr; logic lr; logic fc; logic lc; } win_rec_t;

    wr_rec_t  obs_wr[$];
    win_rec_t obs_win[$];
    int       lens[$];
    int       cyc, stray, bot_cnt;
    bit       exp_ovf;
    int       n_vec, n_err;

    line_buf_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .de(de), .vsync(vsync),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .mid_bank(mid_bank), .top_bank(top_bank), .bot_repl(bot_repl),
        .win_valid(win_valid), .first_row(first_row), .last_row(last_row),
        .first_col(first_col), .last_col(last_col), .line_cnt(line_cnt),
        .err_ovf(err_ovf)
`ifdef LBC_LEN_CHECK_EN
        , .err_len(err_len)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            wr_rec_t  r;
            win_rec_t w;
            cyc++;
            if (wr_en) begin
                r.cyc = cyc; r.bank = int'(wr_bank); r.addr = int'(wr_addr);
                r.mid = int'(mid_bank); r.top = int'(top_bank);
                obs_wr.push_back(r);
            end
            if (win_valid) begin
                w.cyc = cyc; w.fr = first_row; w.lr = last_row; w.fc = first_col; w.lc = last_col;
                obs_win.push_back(w);
            end else if (first_row | last_row | first_col | last_col) begin
                stray++;
            end
            if (bot_repl) bot_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampw(input int x);
        return (x > W) ? W : x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic drive_line(input int d);
        de = 1'b1;
        repeat (d) tick();
        de = 1'b0;
        repeat ($urandom_range(2, 5)) tick();
    endtask

    task automatic end_frame();
        vsync = 1'b1;
        repeat (20) tick();
    endtask

    task automatic clear_obs();
        obs_wr.delete();
        obs_win.delete();
        bot_cnt = 0;
        stray   = 0;
    endtask

    // Model: line i goes to bank i mod 3 at columns 0..len-1; windows for line i>=1
    // appear one cycle after its writes, then line 0's length worth of flush windows.
    task automatic check_frame();
        int n, l0, idx;
        int exp_bank[$], exp_addr[$], line_base[$];
        win_rec_t ew[$];
        win_rec_t w;
        n  = lens.size();
        l0 = clampw(lens[0]);
        for (int i = 0; i < n; i++) begin
            line_base.push_back(exp_bank.size());
            if (lens[i] > W) exp_ovf = 1'b1;
`ifdef LBC_LEN_CHECK_EN
            if (i > 0 && clampw(lens[i]) != l0) exp_len_err = 1'b1;
`endif
            for (int j = 0; j < clampw(lens[i]); j++) begin
                exp_bank.push_back(i % 3);
                exp_addr.push_back(j);
            end
        end
        for (int i = 1; i < n; i++) begin
            for (int j = 0; j < clampw(lens[i]); j++) begin
                idx   = line_base[i] + j;
                w.cyc = (idx < obs_wr.size()) ? obs_wr[idx].cyc + 1 : -1;
                w.fr  = (i == 1); w.lr = 1'b0; w.fc = (j == 0); w.lc = (j == l0 - 1);
                ew.push_back(w);
            end
        end
        for (int j = 0; j < l0; j++) begin
            w.cyc = (j == 0) ? -1 : -2;
            w.fr  = (n == 1); w.lr = 1'b1; w.fc = (j == 0); w.lc = (j == l0 - 1);
            ew.push_back(w);
        end

        chk("wr_count", obs_wr.size(), exp_bank.size());
        for (int k = 0; k < exp_bank.size() && k < obs_wr.size(); k++) begin
            chk("wr_bank", obs_wr[k].bank, exp_bank[k]);
            chk("wr_addr", obs_wr[k].addr, exp_addr[k]);
            chk("mid_bank", obs_wr[k].mid, (exp_bank[k] + 2) % 3);
            chk("top_bank", obs_wr[k].top, (exp_bank[k] + 1) % 3);
        end
        chk("win_count", obs_win.size(), ew.size());
        for (int k = 0; k < ew.size() && k < obs_win.size(); k++) begin
            if (ew[k].cyc >= 0)
                chk("win_cycle", obs_win[k].cyc, ew[k].cyc);
            else if (ew[k].cyc == -2)
                chk("flush_cycle", obs_win[k].cyc, obs_win[k-1].cyc + 1);
            chk("win_flags", {obs_win[k].fr, obs_win[k].lr, obs_win[k].fc, obs_win[k].lc},
                             {ew[k].fr, ew[k].lr, ew[k].fc, ew[k].lc});
        end
        chk("bot_repl_cycles", bot_cnt, l0);
        chk("stray_flags", stray, 0);
        chk("line_cnt", line_cnt, (n < D) ? n : D);
        chk("err_ovf", err_ovf, exp_ovf);
        chk("idle_win_valid", win_valid, 0);
`ifdef LBC_LEN_CHECK_EN
        chk("err_len", err_len, exp_len_err);
`endif
        clear_obs();
    endtask

    task automatic run_frame();
        start_frame();
        foreach (lens[i]) drive_line(lens[i]);
        end_frame();
        check_frame();
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; stray = 0; bot_cnt = 0; exp_ovf = 1'b0;
`ifdef LBC_LEN_CHECK_EN
        exp_len_err = 1'b0;
`endif
        rst = 1'b1; de = 1'b0; vsync = 1'b0;
        #12;
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_bank", wr_bank, 0);
        chk("reset_mid_top", {mid_bank, top_bank}, {2'd2, 2'd1});
        chk("reset_win_flags", {win_valid, first_row, last_row, first_col, last_col}, 0);
        chk("reset_line_cnt", line_cnt, 0);
        chk("reset_err_ovf", err_ovf, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        lens = '{12, 12, 12, 12, 12};
        run_frame();
        lens = '{12, 12, 10, 12};
        run_frame();

        repeat (6) begin
            int n, l0;
            n  = int'($urandom_range(1, 7));
            l0 = int'($urandom_range(6, 12));
            lens.delete();
            lens.push_back(l0);
            for (int i = 1; i < n; i++)
                lens.push_back(($urandom_range(0, 3) != 0) ? l0 : int'($urandom_range(4, 12)));
            run_frame();
        end

        lens = '{12};
        run_frame();

        // overflow: de held 14 cycles on a 12-pixel line
        lens = '{14};
        start_frame();
        de = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            chk("ovf_wr_en", wr_en, (c <= W) ? 1 : 0);
            chk("ovf_wr_addr", wr_addr, (c <= W) ? c - 1 : W - 1);
            chk("ovf_err", err_ovf, (c > W) ? 1 : 0);
            tick();
        end
        de = 1'b0;
        repeat (3) tick();
        end_frame();
        check_frame();

        // asynchronous reset in the middle of a RUN line
        lens = '{12};
        start_frame();
        drive_line(12);
        de = 1'b1;
        repeat (5) tick();
        chk("pre_rst_win_valid", win_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_win_flags", {win_valid, first_row, last_row, first_col, last_col}, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_line_cnt", line_cnt, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_bot_repl", bot_repl, 0);
        de = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        clear_obs();
        exp_ovf = 1'b0;
`ifdef LBC_LEN_CHECK_EN
        exp_len_err = 1'b0;
`endif
        lens = '{12, 12, 9};
        run_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
